// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg
// Shared defaults and types for the PWM controller slice.
//   NCH_DEF  default number of PWM channels
//   CW_DEF   default counter / duty width (period is 2^CW counts)
//   PW_DEF   default prescaler width
//   duty_t   duty value type at the default width
//   MAX_CNT  last count of a period at the default width
package pwm_ctrl_pkg;

    localparam int NCH_DEF = 4;
    localparam int CW_DEF  = 8;
    localparam int PW_DEF  = 8;

    typedef logic [CW_DEF-1:0] duty_t;

    localparam duty_t MAX_CNT = duty_t'((1 << CW_DEF) - 1);

endpackage

// File: rtl/pwm_ctrl_rr_arbiter.sv
// rr_arbiter
// Round-robin arbiter with a registered search pointer.
//   clk    rising-edge clock
//   rst    synchronous active-high reset, pointer returns to 0
//   req    N-wide request vector
//   grant  one-hot (or zero) grant, combinational from req and pointer
// After a grant to index i the pointer moves to (i+1) mod N, so the
// winner becomes the lowest-priority requester on the next cycle.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PTRW = (N > 1) ? $clog2(N) : 1;
    localparam logic [PTRW-1:0] LAST = PTRW'(N - 1);

    logic [PTRW-1:0] ptr;
    logic [PTRW-1:0] cand;
    logic [PTRW-1:0] win;
    logic            found;

    // Walk the request vector once, starting at the pointer and wrapping
    // at N-1, so non-power-of-two widths wrap correctly; the first
    // requester seen wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        win   = ptr;
        cand  = ptr;
        for (int k = 0; k < N; k++) begin
            if (!found && req[cand]) begin
                grant[cand] = 1'b1;
                found       = 1'b1;
                win         = cand;
            end
            cand = (cand == LAST) ? '0 : cand + PTRW'(1);
        end
    end

    // Pointer only moves when something was granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (win == LAST) ? '0 : win + PTRW'(1);
        end
    end

endmodule

// File: rtl/pwm_ctrl.sv
// pwm_ctrl
// Multi-channel PWM generator sharing one prescaled period counter, with
// double-buffered duty updates committed at the period boundary.
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   en            run enable for prescaler and period counter
//   prescale      tick divider, one counter tick every prescale+1 cycles
//   upd_valid     per-channel duty update request
//   upd_duty      per-channel requested duty, channel i at [i*CW +: CW]
//   upd_ready     per-channel grant, combinational, one-hot or zero
//   pwm_out       registered PWM outputs
//   period_start  registered one-cycle strobe marking the start of a period
module pwm_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int CW  = CW_DEF,
    parameter int PW  = PW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [PW-1:0]     prescale,
    input  logic [NCH-1:0]    upd_valid,
    input  logic [NCH*CW-1:0] upd_duty,
    output logic [NCH-1:0]    upd_ready,
    output logic [NCH-1:0]    pwm_out,
    output logic              period_start
);

    // Last count of a period at this instance's width.
    localparam logic [CW-1:0] CNT_TOP = {CW{1'b1}};

    logic [PW-1:0]  psc;
    logic [CW-1:0]  cnt;
    logic           tick;
    logic           wrap;
    logic           en_prev;
    logic [NCH-1:0] req;
    logic [NCH-1:0] grant;
    logic [NCH-1:0] xfer;
    logic [NCH-1:0] pending;
    logic [CW-1:0]  shadow [NCH];
    logic [CW-1:0]  active [NCH];

    // The >= compare means lowering prescale below the running count
    // fires a tick immediately instead of waiting for the prescaler to
    // roll over its full range.
    assign tick = en && (psc >= prescale);
    assign wrap = tick && (cnt == CNT_TOP);

    // Requests are masked on the wrap cycle so a transfer never lands in
    // the same cycle as a commit, and masked during reset so upd_ready
    // stays low.
    assign req       = (rst || wrap) ? '0 : (upd_valid & ~pending);
    assign upd_ready = grant;
    assign xfer      = upd_valid & upd_ready;

    rr_arbiter #(
        .N(NCH)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .grant (grant)
    );

    // Prescaler and period counter. Both are held at 0 while disabled so
    // that re-enabling always starts a fresh period from count 0.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            psc <= '0;
            cnt <= '0;
        end else if (tick) begin
            psc <= '0;
            cnt <= cnt + CW'(1);
        end else begin
            psc <= psc + PW'(1);
        end
    end

    // Output stage. period_start fires after every wrap and after the
    // first enabled cycle; en_prev remembers the previous enable so the
    // latter case can be detected.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_prev      <= 1'b0;
            period_start <= 1'b0;
            pwm_out      <= '0;
        end else begin
            en_prev      <= en;
            period_start <= en && (wrap || !en_prev);
            for (int i = 0; i < NCH; i++) begin
                pwm_out[i] <= en && (cnt < active[i]);
            end
        end
    end

    // Duty double buffer. While running, an accepted update parks in the
    // shadow register and is flagged pending until the next wrap copies
    // it into the active register. While stopped there is no period to
    // protect, so updates go straight to active. Pending flags survive
    // en dropping and commit at the first wrap once running again.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            for (int i = 0; i < NCH; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else if (wrap) begin
            for (int i = 0; i < NCH; i++) begin
                if (pending[i]) begin
                    active[i] <= shadow[i];
                end
            end
            pending <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (xfer[i]) begin
                    shadow[i] <= upd_duty[i*CW +: CW];
                    if (en) begin
                        pending[i] <= 1'b1;
                    end else begin
                        active[i] <= upd_duty[i*CW +: CW];
                    end
                end
            end
        end
    end

endmodule

// File: doc/pwm_ctrl.md
PWM_CTRL -- requirements
Module: pwm_ctrl

Interface
REQ-001 Parameter NCH, 4, number of PWM channels sharing one period counter.
REQ-002 Parameter CW, 8, period-counter and duty width; period is 2^CW counts.
REQ-003 Parameter PW, 8, prescaler width.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  run enable for prescaler and period counter.
REQ-007 prescale  input  PW  tick divider; one tick every prescale+1 cycles.
REQ-008 upd_valid  input  NCH  per-channel duty-update request.
REQ-009 upd_duty  input  NCH*CW  per-channel requested duty; channel i at bits [i*CW +: CW].
REQ-010 upd_ready  output  NCH  per-channel grant; combinational, one-hot or zero.
REQ-011 pwm_out  output  NCH  registered PWM outputs.
REQ-012 period_start  output  1  registered one-cycle strobe marking count 0.

Function
REQ-013 Prescaler: psc counts up each en=1 cycle; tick when psc >= prescale, and psc returns to 0 on that cycle; prescale=0 gives a tick every cycle; a live prescale decrease below psc yields a tick next cycle.
REQ-014 Period counter cnt increments on tick and wraps from 2^CW-1 to 0; a wrap is a tick with cnt = 2^CW-1.
REQ-015 en=0 holds psc and cnt at 0 and forces pwm_out=0 and period_start=0.
REQ-016 period_start is 1 for exactly one cycle following each wrap, and following the first en=1 cycle after en=0 or reset.
REQ-017 pwm_out[i] is 1 in cycle t+1 iff en=1 and cnt(t) < active[i]; latency is 1 cycle; duty 0 means always low, duty 255 means high 255 of 256 counts.
REQ-018 Each channel has a shadow duty register, an active duty register and a pending bit.
REQ-019 Eligible channel: upd_valid[i]=1 and pending[i]=0.
REQ-020 Round-robin arbiter grants at most one eligible channel per cycle, starting the search at pointer ptr; upd_ready is asserted only for the granted channel.
REQ-021 Transfer = upd_valid[i] & upd_ready[i]; the transfer writes shadow[i] and, with en=1, sets pending[i]; ptr becomes (i+1) mod NCH; ptr is unchanged when there is no grant.
REQ-022 Commit on every wrap cycle: active[j] loads shadow[j] for every pending[j], then all pending bits clear; the new duty governs the period beginning at cnt=0.
REQ-023 On a wrap cycle, upd_ready is all zero; no transfer coincides with a commit.
REQ-024 With en=0, a transfer writes shadow[i] and active[i] directly, and pending[i] stays 0.
REQ-025 A pending channel holding valid high is back-pressured until the cycle after the next commit.
REQ-026 Pending bits persist when en falls; they commit at the first wrap after en returns.

Reset
REQ-027 With rst=1 at a clock edge: psc, cnt, ptr, all shadow, active and pending are 0; pwm_out=0, period_start=0; upd_ready=0 during rst.
REQ-028 Reset mid-period or mid-handshake discards pending updates, and no commit occurs.
REQ-029 rst has priority over en and all updates.

Structure
REQ-030 Shared package pwm_ctrl_pkg holds NCH/CW/PW defaults, the duty_t (CW-bit) typedef and the MAX_CNT constant.
REQ-031 One sub-module rr_arbiter (NCH-wide request, one-hot grant, pointer update) is instantiated once.
REQ-032 The remainder (prescaler, counter, shadow/active/pending, compare) stays flat in pwm_ctrl; target 150-300 lines.

Verification
REQ-033 Test: prescale=0, en=1, reset release, ch0 update 64 -> first period_start next cycle after en; ch0 high counts 64 of 256 starting from the first period after commit.
REQ-034 Test: upd_valid=4'b1111 at once with ptr=0 -> grants ch0, ch1, ch2, ch3 on successive cycles; a second ch0 request is stalled until after the wrap.
REQ-035 Test: ch2 valid held on the wrap cycle (cnt=255, tick) -> upd_ready=0 that cycle, grant next cycle, pending commits at the following wrap.
REQ-036 Test: prescale=3 -> tick every 4 cycles; period length 1024 cycles; period_start spacing 1024.
REQ-037 Test: en=0, update ch1 to 200, then en=1 -> ch1 high 200 counts in the very first period; duty 0 and 255 boundaries hold.
REQ-038 Test: rst asserted at cnt=100 with ch3 pending -> all outputs 0 the next cycle; after release, ch3 active stays 0.
